// File: rtl/cdc_pulse_scheduler.sv
// cdc_pulse_scheduler
//   Fast-domain front end for a toggle-based fast-to-slow pulse CDC. Counts
//   single-cycle events from N_REQ requesters, shares the single CDC channel
//   among them round-robin, and keeps issued pulses at least MIN_GAP cycles
//   apart so the slow side never sees two toggles merge.
// Ports
//   i_clk      fast clock, the only clock of the block
//   i_rst_n    asynchronous active-low reset (release is synchronised here)
//   i_req      per-requester event, one event per high cycle
//   i_en       1 = issuing allowed; 0 = hold issues (counting and gap continue)
//   i_ovf_clr  clears the sticky overflow flags
//   o_pulse    registered single-cycle pulse to the CDC
//   o_id       requester served by the latest pulse, held until the next one
//   o_pend     bit i set while requester i has pending events
//   o_ovf      sticky: an event of requester i was dropped at saturation
module cdc_pulse_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  input  logic             i_ovf_clr,
  output logic             o_pulse,
  output logic [ID_W-1:0]  o_id,
  output logic [N_REQ-1:0] o_pend,
  output logic [N_REQ-1:0] o_ovf
);

  // MIN_GAP=1 needs no countdown, but keep the register at least one bit wide.
  localparam int                GAP_W      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [ID_W-1:0]   RR_INIT    = ID_W'(N_REQ - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_core_n_s;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             pulse_q, pulse_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] pend_s;
  logic [N_REQ-1:0] dec_s;
  logic [N_REQ-1:0] ovf_set_s;
  logic [ID_W-1:0]  winner_s;
  logic             found_s;
  logic             issue_s;

  // Index k steps after base, wrapping at N_REQ (works for non-power-of-2 N_REQ).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return ID_W'(sum % N_REQ);
  endfunction

  // Reset synchroniser: assertion is immediate, release is aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_core_n_s = rst_sync_q[1];

  // Pending flags straight from the registered counts.
  always_comb begin
    pend_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      pend_s[i] = (cnt_q[i] != {CNT_W{1'b0}});
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found_s  = 1'b0;
    winner_s = rr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found_s && pend_s[rr_index(rr_q, k)]) begin
        found_s  = 1'b1;
        winner_s = rr_index(rr_q, k);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign issue_s = i_en && (gap_q == {GAP_W{1'b0}}) && found_s;

  // Next-state for pulse, id, pointer, gap timer, counters and overflow flags.
  always_comb begin
    pulse_d   = issue_s;
    id_d      = issue_s ? winner_s : id_q;
    rr_d      = issue_s ? winner_s : rr_q;
    ovf_set_s = {N_REQ{1'b0}};
    dec_s     = {N_REQ{1'b0}};

    if (issue_s) begin
      gap_d = GAP_RELOAD;
    end else if (gap_q != {GAP_W{1'b0}}) begin
      gap_d = gap_q - GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end

    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      dec_s[i] = issue_s && (winner_s == ID_W'(i));
      // An event arriving on the grant edge replaces the one being issued.
      case ({i_req[i], dec_s[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_set_s[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    // A new overflow in the same cycle as a clear keeps its flag set.
    ovf_d = (i_ovf_clr ? {N_REQ{1'b0}} : ovf_q) | ovf_set_s;
  end

  // State registers.
  always_ff @(posedge i_clk or negedge rst_core_n_s) begin
    if (!rst_core_n_s) begin
      pulse_q <= 1'b0;
      id_q    <= {ID_W{1'b0}};
      rr_q    <= RR_INIT;
      gap_q   <= {GAP_W{1'b0}};
      ovf_q   <= {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      pulse_q <= pulse_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_pulse = pulse_q;
  assign o_id    = id_q;
  assign o_pend  = pend_s;
  assign o_ovf   = ovf_q;

endmodule
